// File: rtl/tdc_toa_hit_buffer.sv
// ============================================================================
// Module      : tdc_toa_hit_buffer
// Description : Captures encoded TOA hits, applies error and window filters,
//               and buffers accepted hits in a first-word-fall-through FIFO
//               that the pixel readout drains over valid/ready. Keeps
//               saturating hit, reject and drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_toa_hit_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit_valid,
    input  logic [2:0]       coarse_phase,
    input  logic [6:0]       fine_phase,
    input  logic             error_flag,
    input  logic             drop_err,
    input  logic             win_en,
    input  logic [9:0]       win_lo,
    input  logic [9:0]       win_hi,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [11:0]      rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             clr_stat,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] rej_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Storage and pointers
    logic [11:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] occ_after_pop;
    logic [11:0]      rd_data_q, rd_data_d;

    // Statistics state
    logic [CNT_W-1:0] hit_cnt_q, rej_cnt_q, drop_cnt_q;
    logic             overflow_q;
    logic             ovf_pending_q;

    // Hit qualification
    logic [9:0]  toa;
    logic        rej_err;
    logic        rej_win;
    logic        qualified;
    logic        is_full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        reject;
    logic [11:0] push_word;

    // Concatenation equals coarse*128 + fine
    assign toa       = {coarse_phase, fine_phase};
    assign rej_err   = drop_err & error_flag;
    // An inverted window (lo > hi) can never be satisfied, so it rejects everything
    assign rej_win   = win_en & ((toa < win_lo) | (toa > win_hi));
    assign qualified = hit_valid & ~rej_err & ~rej_win;
    assign reject    = hit_valid & (rej_err | rej_win);

    assign is_full   = (occ_q == OCC_FULL);
    assign rd_valid  = (occ_q != '0);
    assign pop       = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push      = qualified & (~is_full | pop);
    assign drop      = qualified & is_full & ~pop;
    assign push_word = {error_flag, ovf_pending_q, toa};

    assign occ_after_pop = occ_q - OCC_W'(pop);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next pointer/occupancy and the word to present at the head next cycle
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        occ_d     = occ_after_pop + OCC_W'(push);
        rd_data_d = rd_data_q;
        if (occ_d != '0) begin
            // When the FIFO drains to zero this cycle, the new word bypasses memory
            if (push && (occ_after_pop == '0)) begin
                rd_data_d = push_word;
            end else begin
                rd_data_d = mem[rd_ptr_d];
            end
        end
    end

    // Storage write; contents need no reset since occupancy gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // FIFO control registers and registered head word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Statistics, sticky overflow and the mark for the first word after drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q     <= '0;
            rej_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            overflow_q    <= 1'b0;
            ovf_pending_q <= 1'b0;
        end else if (clr_stat) begin
            hit_cnt_q     <= '0;
            rej_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            overflow_q    <= 1'b0;
            ovf_pending_q <= 1'b0;
        end else begin
            if (push) begin
                hit_cnt_q <= sat_inc(hit_cnt_q);
            end
            if (reject) begin
                rej_cnt_q <= sat_inc(rej_cnt_q);
            end
            if (drop) begin
                drop_cnt_q    <= sat_inc(drop_cnt_q);
                overflow_q    <= 1'b1;
                ovf_pending_q <= 1'b1;
            end else if (push) begin
                ovf_pending_q <= 1'b0;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign full     = is_full;
    assign empty    = (occ_q == '0);
    assign overflow = overflow_q;
    assign hit_cnt  = hit_cnt_q;
    assign rej_cnt  = rej_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_toa_hit_buffer.sv
// ============================================================================
// Module      : tb_tdc_toa_hit_buffer
// Description : Directed and randomized stimulus for tdc_toa_hit_buffer,
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdc_toa_hit_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             hit_valid;
    logic [2:0]       coarse_phase;
    logic [6:0]       fine_phase;
    logic             error_flag;
    logic             drop_err;
    logic             win_en;
    logic [9:0]       win_lo;
    logic [9:0]       win_hi;
    logic             rd_ready;
    logic             rd_valid;
    logic [11:0]      rd_data;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             clr_stat;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] rej_cnt;
    logic [CNT_W-1:0] drop_cnt;

    tdc_toa_hit_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hit_valid    (hit_valid),
        .coarse_phase (coarse_phase),
        .fine_phase   (fine_phase),
        .error_flag   (error_flag),
        .drop_err     (drop_err),
        .win_en       (win_en),
        .win_lo       (win_lo),
        .win_hi       (win_hi),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_stat     (clr_stat),
        .hit_cnt      (hit_cnt),
        .rej_cnt      (rej_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [11:0] m_q[$];
    int          m_hit, m_rej, m_drop;
    bit          m_ovf, m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hit = 0; m_rej = 0; m_drop = 0;
        m_ovf = 0; m_pend = 0;
    endtask

    task automatic compare_all();
        check("rd_valid", rd_valid, m_q.size() > 0);
        if (m_q.size() > 0) check("rd_data", rd_data, m_q[0]);
        check("full", full, m_q.size() == DEPTH);
        check("empty", empty, m_q.size() == 0);
        check("overflow", overflow, m_ovf);
        check("hit_cnt", hit_cnt, m_hit);
        check("rej_cnt", rej_cnt, m_rej);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // One clock cycle of stimulus; model advances at the edge, outputs checked 1ns later
    task automatic cycle(input bit hv, input int toa, input bit e, input bit rdy, input bit clr);
        logic [9:0]  t;
        logic [11:0] word;
        bit pop, push, drop, rej;
        t = toa[9:0];
        hit_valid    = hv;
        coarse_phase = t[9:7];
        fine_phase   = t[6:0];
        error_flag   = e;
        rd_ready     = rdy;
        clr_stat     = clr;
        pop  = (m_q.size() > 0) && rdy;
        push = 0; drop = 0; rej = 0;
        if (hv) begin
            if (drop_err && e)                              rej  = 1;
            else if (win_en && (int'(t) < int'(win_lo) || int'(t) > int'(win_hi))) rej = 1;
            else if (m_q.size() == DEPTH && !pop)           drop = 1;
            else                                            push = 1;
        end
        word = {e, m_pend, t};
        @(posedge clk);
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(word);
        if (clr) begin
            m_hit = 0; m_rej = 0; m_drop = 0; m_ovf = 0; m_pend = 0;
        end else begin
            if (push) m_hit = sat(m_hit);
            if (rej)  m_rej = sat(m_rej);
            if (drop) begin
                m_drop = sat(m_drop); m_ovf = 1; m_pend = 1;
            end else if (push) begin
                m_pend = 0;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (m_q.size() > 0) cycle(0, 0, 0, 1, 0);
        end
    endtask

    initial begin
        reset = 1; hit_valid = 0; coarse_phase = 0; fine_phase = 0; error_flag = 0;
        drop_err = 0; win_en = 0; win_lo = 0; win_hi = 0; rd_ready = 0; clr_stat = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 0;

        // Single hit: coarse=3, fine=5 -> 389
        cycle(1, 389, 0, 0, 0);
        check("t1_data", rd_data, 12'h185);
        check("t1_hit", hit_cnt, 1);
        cycle(0, 0, 0, 1, 0);
        check("t1_empty", empty, 1);

        // Fill past capacity, drain, then the overflow mark on the next push
        for (int i = 10; i < 16; i++) cycle(1, i, 0, 0, 0);
        check("t2_drop", drop_cnt, 2);
        check("t2_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check("t2_drain", rd_data, 10 + i);
            cycle(0, 0, 0, 1, 0);
        end
        cycle(1, 20, 0, 0, 0);
        check("t2_mark", rd_data, 12'h414);
        cycle(1, 21, 0, 1, 0);
        check("t2_nomark", rd_data, 12'h015);

        // Push and pop together while full
        drain();
        for (int i = 0; i < 4; i++) cycle(1, 100 + i, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 200 + i, 0, 1, 0);
            check("t3_full", full, 1);
        end
        check("t3_head", rd_data, 206);

        // Filters
        drain();
        cycle(0, 0, 0, 0, 1);
        drop_err = 1;
        cycle(1, 50, 1, 0, 0);
        check("t4_rej_err", rej_cnt, 1);
        drop_err = 0;
        cycle(1, 50, 1, 0, 0);
        check("t4_errword", rd_data, 12'h832);
        drain();
        win_en = 1; win_lo = 100; win_hi = 200;
        cycle(1, 99, 0, 0, 0);
        cycle(1, 100, 0, 0, 0);
        cycle(1, 200, 0, 0, 0);
        cycle(1, 201, 0, 0, 0);
        check("t4_win_rej", rej_cnt, 3);
        check("t4_win_head", rd_data, 100);
        win_lo = 300; win_hi = 100;
        cycle(1, 150, 0, 0, 0);
        check("t4_inverted", rej_cnt, 4);
        win_en = 0;

        // Saturation and clear-wins
        drain();
        for (int i = 0; i < 20; i++) cycle(1, 400 + i, 0, 1, 0);
        check("t5_sat", hit_cnt, CMAX);
        drain();
        cycle(1, 333, 0, 0, 1);
        check("t5_clr", hit_cnt, 0);
        check("t5_data", rd_data, 333);

        // Reset mid-operation
        drain();
        for (int i = 0; i < 3; i++) cycle(1, 500 + i, 0, 0, 0);
        #2;
        reset = 1;
        #1;
        model_reset();
        check("t6_empty", empty, 1);
        check("t6_valid", rd_valid, 0);
        check("t6_hit", hit_cnt, 0);
        hit_valid = 1;
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 0;
        hit_valid = 0;
        cycle(1, 77, 0, 0, 0);
        check("t6_first", rd_data, 77);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                drop_err = 1'($urandom_range(0, 1));
                win_en   = 1'($urandom_range(0, 1));
                win_lo   = 10'($urandom_range(0, 600));
                win_hi   = 10'($urandom_range(300, 1023));
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tdc_toa_hit_buffer.md
Name: tdc_toa_hit_buffer

Overview:
Downstream stage of the TOA encoder. It captures each encoded hit (3-bit coarse phase, 7-bit fine phase, error flag) on a per-hit strobe. It forms the 10-bit TOA code, applies error and time-window filtering, and buffers accepted hits in a small FIFO. The FIFO is drained by the pixel readout through a valid/ready handshake, and the block keeps hit, reject and drop statistics.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
CNT_W, 16, width of saturating statistics counters

Ports:
clk  input  1  system clock, 40 MHz
reset  input  1  asynchronous, active-high reset
hit_valid  input  1  one-cycle strobe: encoder outputs valid this cycle
coarse_phase  input  3  encoder coarse phase
fine_phase  input  7  encoder fine phase
error_flag  input  1  encoder bubble/error flag
drop_err  input  1  1 = discard hits with error_flag set
win_en  input  1  1 = enable TOA window filter
win_lo  input  10  window lower bound, inclusive
win_hi  input  10  window upper bound, inclusive
rd_ready  input  1  readout accepts word
rd_valid  output  1  head word valid
rd_data  output  12  {error_flag, ovf_mark, toa[9:0]}
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
overflow  output  1  sticky: a hit was lost to full FIFO
clr_stat  input  1  synchronous clear of counters and overflow
hit_cnt  output  CNT_W  accepted hits, saturating
rej_cnt  output  CNT_W  hits rejected by error or window filter, saturating
drop_cnt  output  CNT_W  hits lost to full FIFO, saturating

Behaviour:
- Reset values: all outputs 0 except empty=1. FIFO pointers and occupancy are 0, ovf_pending is 0.
- TOA formation: toa = coarse_phase*128 + fine_phase, unsigned 10 bits, range 0..1023, no offset applied.
- Hit qualification happens in the cycle hit_valid=1. Checks are prioritised in this order:
  1. drop_err & error_flag: reject; rej_cnt += 1.
  2. win_en & (toa < win_lo | toa > win_hi): reject; rej_cnt += 1. If win_lo > win_hi, every hit is rejected while win_en=1.
  3. FIFO full and no pop this cycle: drop; drop_cnt += 1; overflow <= 1; ovf_pending <= 1.
  4. Otherwise: push; hit_cnt += 1.
- Pushed word: {error_flag, ovf_pending, toa}. ovf_pending is cleared on that push, so only the first word written after one or more drops carries ovf_mark=1.
- FIFO is first-word-fall-through with registered outputs.
  - A hit pushed into an empty FIFO at edge N gives rd_valid=1 and rd_data valid after edge N, i.e. visible in cycle N+1.
  - Pop occurs when rd_valid & rd_ready at a clock edge; the next word is presented the following cycle.
  - rd_data is held stable while rd_valid=1 & rd_ready=0.
  - rd_data is don't-care when rd_valid=0; the implementation holds the last value.
- Simultaneous push and pop:
  - Allowed in any occupancy.
  - When full, the pop frees a slot and the push is accepted; no drop, full stays 1.
  - When empty, a pop cannot occur.
- Pointers wrap modulo DEPTH. full and empty are derived from an occupancy counter of log2(DEPTH)+1 bits.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_stat=1: at the next edge, hit_cnt, rej_cnt, drop_cnt, overflow and ovf_pending go to 0. FIFO contents are untouched. A hit in the same cycle is qualified normally, but its counter increment is lost (clear wins).
- hit_valid on consecutive cycles is legal; each cycle is an independent hit.
- Reset asserted mid-operation: FIFO is emptied immediately (asynchronously) and all state returns to reset values. Hits during reset are ignored.

Test Plan:
1. Single hit: coarse=3, fine=5, error_flag=0, filters off, rd_ready=0 → next cycle rd_valid=1, rd_data=0x185 (toa=389), hit_cnt=1; rd_ready=1 for one cycle → empty=1, rd_valid=0.
2. Fill and overflow (DEPTH=4, rd_ready=0): push 6 hits, toa=10..15 → full=1, drop_cnt=2, overflow=1. Then drain 4 words: 10, 11, 12, 13, all with ovf_mark=0. Push toa=20 → word 0x414 (ovf_mark=1). Push toa=21 → ovf_mark=0.
3. Push and pop while full: keep FIFO full with rd_ready=1 and hit_valid every cycle → no drops, full stays 1, output order matches input order.
4. Filters:
   - drop_err=1, error_flag=1 → rejected, rej_cnt+1.
   - drop_err=0, error_flag=1 → pushed with bit11=1.
   - win_en=1, win_lo=100, win_hi=200: toa=99 rejected, 100 accepted, 200 accepted, 201 rejected.
5. Saturation and clear: CNT_W=4, push/pop 20 hits → hit_cnt=15. Assert clr_stat in the same cycle as a hit → hit_cnt=0 next cycle, and the hit still appears at rd_data.
6. Reset mid-operation: 3 words buffered, assert reset between edges → empty=1, rd_valid=0 and counters 0 immediately. After release, the first hit appears one cycle after its strobe.
